mux_rr_n: RTL and testbench
===========================

Name: mux_rr_n

Overview:
- Parametrised N-input, W-bit registered multiplexer; successor to the 2:1 combinational mux used in the lab datapath.
- Adds per-channel valid/ready handshakes, a one-entry output register, and two select modes:
  - manual: an external select, like the old S input.
  - round-robin: fair arbitration across all channels.
- Sits between several producers (register-file read ports, ALU results) and a single consumer bus.

Parameters:
- N, 4, number of input channels (>=2).
- W, 8, data width per channel.
- SW, $clog2(N), select/pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i has a word.
- in_ready  output  N  channel i word accepted this cycle.
- mode  input  1  0 = MODE_MANUAL, 1 = MODE_RR.
- sel  input  SW  manual-mode channel select.
- out_data  output  W  registered selected word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts out_data.
- out_src  output  SW  channel index that produced out_data.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_src=0, rr pointer ptr=0.
  - A held word is discarded.
  - in_ready is all-zero while rst_n=0.
- load = !out_valid || out_ready. The register can take a new word in the same cycle the old one leaves, so back-to-back throughput is 1 word/cycle.
- Grant, combinational:
  - MODE_MANUAL: grant_vld = (sel < N) && in_valid[sel], and grant = sel. If sel >= N, grant_vld=0 and nothing is accepted.
  - MODE_RR: search channels ptr, ptr+1, …, ptr+N-1 (mod N). grant = first with in_valid set; grant_vld = |in_valid.
- in_ready[i] = load && grant_vld && (grant == i). At most one bit is set (one-hot or zero).
- Transfer on a clock edge where load && grant_vld:
  - out_data <= channel grant.
  - out_src <= grant.
  - out_valid <= 1.
- If load && !grant_vld, then out_valid <= 0 and out_data/out_src hold their previous value.
- If !load (stall: out_valid=1, out_ready=0), all outputs hold and in_ready=0.
- Latency: input accepted at edge k appears on out_data after edge k, i.e. 1 cycle.
- ptr update:
  - Only in MODE_RR, on a transfer: ptr <= (grant == N-1) ? 0 : grant+1. This is an explicit wrap; N need not be a power of two.
  - MODE_MANUAL never changes ptr.
- A mode change takes effect on the next grant evaluation. A word already held in the output register is unaffected.
- Producers must hold in_data/in_valid stable until in_ready. The block does not check this.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {MODE_MANUAL=1'b0, MODE_RR=1'b1} mux_mode_e.
  - Helper function next_ptr(grant, N) implementing the wrap rule.
- Sub-module rr_arbiter #(N):
  - inputs: req[N], ptr[SW].
  - outputs: gnt_idx[SW], gnt_vld.
  - Purely combinational priority rotation.
- mux_rr_n owns ptr, the output register, and the manual/rr select.

Test Plan (N=4, W=8):
1. Reset mid-stream: hold out_valid=1, out_data=8'hA5, then pulse rst_n=0 between clock edges -> out_valid=0, out_data=0 immediately (no edge needed), in_ready=4'b0000.
2. Manual mode, sel=2, in_valid=4'b1111, in_data ch2=8'h3C, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'h3C, out_src=2, out_valid=1. With sel=3 and in_valid[3]=0 -> in_ready=0, and out_valid drops to 0 the following cycle.
3. Round-robin fairness: all four channels valid continuously with data 8'h10..8'h13, out_ready=1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles; ptr wraps 3->0.
4. Round-robin skip: in_valid=4'b1010, ptr=0 -> grant 1, then 3, then 1. Channels 0 and 2 never get in_ready.
5. Backpressure: out_valid=1, out_ready=0 for 3 cycles with all inputs valid -> in_ready=0 and out_data stable. When out_ready returns to 1, the held word leaves and the next grant loads in the same edge, with no bubble.
6. Mode switch: in MODE_RR with ptr=2, switch to MODE_MANUAL with sel=0 -> channel 0 granted and ptr stays 2. Switch back to MODE_RR -> next grant is channel 2.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-input registered mux.
// Exports the select-mode enum and the round-robin pointer wrap helper.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_e;

  // Advance past the granted channel, wrapping explicitly so N
  // need not be a power of two.
  function automatic int unsigned next_ptr(
    input int unsigned grant,
    input int unsigned n
  );
    return (grant == n - 1) ? 32'd0 : grant + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter; search starts at ptr.
// Ports: req (requests), ptr (start index), gnt_idx/gnt_vld (grant).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest
  // requester to ptr is the last one written and wins.
  always_comb begin
    gnt_idx = '0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (req[w_idx]) gnt_idx = SW'(w_idx);
    end
  end

  assign gnt_vld = |req;

endmodule

// File: rtl/mux_rr_n.sv
// N-input W-bit registered mux with valid/ready and manual/rr select.
// Ports: clk, rst_n, in_* (N producers), mode/sel, out_* (one consumer).
module mux_rr_n
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_src
);

  logic [W-1:0]  r_data;
  logic          r_valid;
  logic [SW-1:0] r_src;
  logic [SW-1:0] r_ptr;

  mux_mode_e     w_mode;
  logic          w_load;
  logic          w_sel_ok;
  logic [SW-1:0] w_arb_idx;
  logic          w_arb_vld;
  logic [SW-1:0] w_grant;
  logic          w_gvld;
  logic          w_xfer;
  logic [W-1:0]  w_word;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_vld (w_arb_vld)
  );

  // Out-of-range manual selects only exist when N is not 2**SW.
  if (N == (1 << SW)) begin : g_pow2
    assign w_sel_ok = 1'b1;
  end else begin : g_npow2
    assign w_sel_ok = (32'(sel) < N);
  end

  assign w_mode = mux_mode_e'(mode);
  assign w_load = !r_valid || out_ready;

  always_comb begin
    w_grant = sel;
    w_gvld  = w_sel_ok && in_valid[sel];
    if (w_mode == MODE_RR) begin
      w_grant = w_arb_idx;
      w_gvld  = w_arb_vld;
    end
  end

  assign w_xfer = w_load && w_gvld;
  assign w_word = in_data[int'(w_grant)*W +: W];

  // rst_n gates ready so nothing is accepted while held in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && w_xfer && (w_grant == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_gvld;
        if (w_gvld) begin
          r_data <= w_word;
          r_src  <= w_grant;
        end
      end
      if (w_xfer && w_mode == MODE_RR) begin
        r_ptr <= SW'(next_ptr(32'(w_grant), N));
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_src   = r_src;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed self-checking bench for mux_rr_n (N=4, W=8).
// Covers reset, manual, rr fairness/skip, backpressure, mode switch.
module tb_mux_rr_n;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_src;

  int n_chk;
  int n_err;

  mux_rr_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d,
                         input logic [1:0] s, input logic v);
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".src"}, 32'(out_src), 32'(s));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
  endtask

  logic [1:0] fair_seq [6];
  logic [1:0] skip_seq [3];
  logic [7:0] skip_dat [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    fair_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    skip_seq = '{2'd1, 2'd3, 2'd1};
    skip_dat = '{8'h40, 8'h21, 8'h42, 8'h23};

    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(8'h10, 8'h11, 8'h3C, 8'h13);
    #2;
    chk_out("reset", 8'h00, 2'd0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    #10 rst_n = 1'b1;
    step();

    // Manual select.
    sel = 2'd2;
    #1 chk("man.in_ready", 32'(in_ready), 32'b0100);
    step();
    chk_out("man", 8'h3C, 2'd2, 1'b1);
    sel      = 2'd3;
    in_valid = 4'b0111;
    #1 chk("man_inv.in_ready", 32'(in_ready), 32'h0);
    step();
    chk_out("man_inv", 8'h3C, 2'd2, 1'b0);

    // Round-robin fairness from ptr=0.
    mode     = 1'b1;
    in_valid = 4'hF;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr%0d.in_ready", i), 32'(in_ready),
             32'(1) << fair_seq[i]);
      step();
      chk_out($sformatf("rr%0d", i), 8'h10 + 8'(fair_seq[i]),
              fair_seq[i], 1'b1);
    end

    // ptr=2 now; manual must not move it.
    mode = 1'b0;
    sel  = 2'd0;
    #1 chk("sw_man.in_ready", 32'(in_ready), 32'b0001);
    step();
    chk_out("sw_man", 8'h10, 2'd0, 1'b1);
    mode = 1'b1;
    #1 chk("sw_rr.in_ready", 32'(in_ready), 32'b0100);
    step();
    chk_out("sw_rr", 8'h12, 2'd2, 1'b1);

    // Backpressure: ptr=3, hold ch2 word for 3 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
      step();
      chk_out($sformatf("bp%0d", i), 8'h12, 2'd2, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel.in_ready", 32'(in_ready), 32'b1000);
    step();
    chk_out("bp_rel", 8'h13, 2'd3, 1'b1);

    // Reset mid-stream with a held word.
    mode = 1'b0;
    sel  = 2'd1;
    set_data(8'h10, 8'hA5, 8'h12, 8'h13);
    #1 chk("pre_rst.in_ready", 32'(in_ready), 32'b0010);
    step();
    chk_out("pre_rst", 8'hA5, 2'd1, 1'b1);
    out_ready = 1'b0;
    step();
    chk_out("stall", 8'hA5, 2'd1, 1'b1);
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 8'h00, 2'd0, 1'b0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
    #3 rst_n = 1'b1;
    step();

    // Round-robin skip from ptr=0.
    mode     = 1'b1;
    in_valid = 4'b1010;
    set_data(skip_dat[0], skip_dat[1], skip_dat[2], skip_dat[3]);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("skip%0d.in_ready", i), 32'(in_ready),
             32'(1) << skip_seq[i]);
      step();
      chk_out($sformatf("skip%0d", i), skip_dat[skip_seq[i]],
              skip_seq[i], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
